univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 25 ++
 rtl/usr_shift_counter.sv | 45 ++++
 rtl/univ_shift_reg.sv | 61 ++++++
 tb/tb_univ_shift_reg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode encodings and decode helpers for the universal shift register.
package usr_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_ROL   = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_RSVD  = 3'b111
    } mode_e;

    function automatic logic is_shift(input logic [MODE_W-1:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

    function automatic logic is_reset_op(input logic [MODE_W-1:0] m);
        return (m == MODE_LOAD) || (m == MODE_CLEAR);
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Counts shifts within a WIDTH-shift word and pulses done for one cycle on word completion.
module usr_shift_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          count_en,
    input  logic          clear,
    output logic [CW-1:0] cnt,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate both ways, parallel load, clear, with word counter.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [MODE_W-1:0] mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_q;
    logic             count_en;
    logic             clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHL:   q_q <= {q_q[WIDTH-2:0], sin_r};
                MODE_SHR:   q_q <= {sin_l, q_q[WIDTH-1:1]};
                MODE_ROL:   q_q <= {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:   q_q <= {q_q[0], q_q[WIDTH-1:1]};
                MODE_LOAD:  q_q <= pdata;
                MODE_CLEAR: q_q <= '0;
                default:    q_q <= q_q;
            endcase
        end
    end

    assign count_en = en & is_shift(mode);
    assign clear    = en & is_reset_op(mode);

    usr_shift_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .clear    (clear),
        .cnt      (cnt),
        .done     (done)
    );

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and randomized bench for univ_shift_reg (WIDTH=4) against an arithmetic reference model.
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned M  = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  pdata;
    logic [W-1:0]  q;
    logic          sout_msb;
    logic          sout_lsb;
    logic [CW-1:0] cnt;
    logic          done;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: register value as an integer, shifts-in-word count, done flag.
    int unsigned mq    = 0;
    int unsigned mcnt  = 0;
    int unsigned mdone = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .pdata    (pdata),
        .q        (q),
        .sout_msb (sout_msb),
        .sout_lsb (sout_lsb),
        .cnt      (cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(q),        32'(mq));
        check({tag, ".cnt"},  32'(cnt),      32'(mcnt));
        check({tag, ".done"}, 32'(done),     32'(mdone));
        check({tag, ".msb"},  32'(sout_msb), 32'((mq >> (W - 1)) & 1));
        check({tag, ".lsb"},  32'(sout_lsb), 32'(mq & 1));
    endtask

    task automatic model_step(input logic e, input logic [2:0] m, input logic sr,
                              input logic sl, input logic [W-1:0] pd);
        int unsigned is_sh;
        is_sh = 0;
        if (e) begin
            case (m)
                3'd1: begin mq = ((mq << 1) | 32'(sr)) & M;             is_sh = 1; end
                3'd2: begin mq = (mq >> 1) | (32'(sl) << (W - 1));      is_sh = 1; end
                3'd3: begin mq = ((mq << 1) | (mq >> (W - 1))) & M;     is_sh = 1; end
                3'd4: begin mq = (mq >> 1) | ((mq & 1) << (W - 1));     is_sh = 1; end
                3'd5: begin mq = 32'(pd); mcnt = 0; end
                3'd6: begin mq = 0;       mcnt = 0; end
                default: ;
            endcase
        end
        mdone = 0;
        if (is_sh != 0) begin
            mcnt = mcnt + 1;
            if (mcnt == W) begin
                mcnt  = 0;
                mdone = 1;
            end
        end
    endtask

    task automatic cycle(input string tag, input logic e, input logic [2:0] m,
                         input logic sr, input logic sl, input logic [W-1:0] pd);
        en = e; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
        @(posedge clk);
        model_step(e, m, sr, sl, pd);
        #1;
        check_all(tag);
    endtask

    // Async reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        rst = 1'b0;
        #1;
        mq = 0; mcnt = 0; mdone = 0;
        check_all(tag);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] rm;
        rst = 1'b1; en = 1'b1; mode = 3'(MODE_LOAD); sin_r = 1'b1; sin_l = 1'b1; pdata = 4'hF;
        #2;
        rst = 1'b0;
        #1;
        check_all("reset_async");
        check("reset_q_const", 32'(q), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // SHL word with 1,0,1,0 shifted in
        cycle("shl1", 1'b1, 3'(MODE_SHL), 1'b1, 1'b0, 4'h0);
        cycle("shl2", 1'b1, 3'(MODE_SHL), 1'b0, 1'b0, 4'h0);
        cycle("shl3", 1'b1, 3'(MODE_SHL), 1'b1, 1'b0, 4'h0);
        check("shl3_done_low", 32'(done), 32'h0);
        cycle("shl4", 1'b1, 3'(MODE_SHL), 1'b0, 1'b0, 4'h0);
        check("shl_word_q", 32'(q), 32'hA);
        check("shl_word_done", 32'(done), 32'h1);
        cycle("shl_after", 1'b1, 3'(MODE_HOLD), 1'b0, 1'b0, 4'h0);
        check("shl_done_drop", 32'(done), 32'h0);

        // Load then rotate
        cycle("load", 1'b1, 3'(MODE_LOAD), 1'b0, 1'b0, 4'b1001);
        cycle("rol",  1'b1, 3'(MODE_ROL),  1'b0, 1'b0, 4'h0);
        check("rol_q", 32'(q), 32'h3);
        cycle("ror1", 1'b1, 3'(MODE_ROR),  1'b0, 1'b0, 4'h0);
        cycle("ror2", 1'b1, 3'(MODE_ROR),  1'b0, 1'b0, 4'h0);
        check("ror_q", 32'(q), 32'hC);

        // SHR interrupted by en=0, then resumed
        cycle("clr",  1'b1, 3'(MODE_CLEAR), 1'b0, 1'b0, 4'h0);
        cycle("shr1", 1'b1, 3'(MODE_SHR),   1'b0, 1'b1, 4'h0);
        check("shr1_q", 32'(q), 32'h8);
        for (int i = 0; i < 3; i++) cycle("hold_en0", 1'b0, 3'(MODE_SHR), 1'b1, 1'b1, 4'hF);
        check("hold_cnt", 32'(cnt), 32'h1);
        cycle("shr2", 1'b1, 3'(MODE_SHR),   1'b0, 1'b1, 4'h0);
        check("shr2_q", 32'(q), 32'hC);
        check("shr2_cnt", 32'(cnt), 32'h2);

        // Interrupted word: 3 shifts, clear, 4 shifts
        for (int i = 0; i < 3; i++) cycle("pre_clr", 1'b1, 3'(MODE_ROL), 1'b1, 1'b0, 4'h0);
        cycle("mid_clear", 1'b1, 3'(MODE_CLEAR), 1'b0, 1'b0, 4'h0);
        check("mid_clear_cnt", 32'(cnt), 32'h0);
        for (int i = 0; i < 4; i++) cycle("post_clr", 1'b1, 3'(MODE_SHL), 1'b1, 1'b0, 4'h0);
        check("post_clr_done", 32'(done), 32'h1);

        // Reserved mode acts as HOLD
        cycle("rsvd", 1'b1, 3'(MODE_RSVD), 1'b1, 1'b1, 4'h5);

        // Reset mid-word
        cycle("rw1", 1'b1, 3'(MODE_SHL), 1'b1, 1'b0, 4'h0);
        cycle("rw2", 1'b1, 3'(MODE_SHL), 1'b1, 1'b0, 4'h0);
        reset_pulse("reset_mid");
        for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 3'(MODE_SHR), 1'b0, 1'b1, 4'h0);
        check("post_rst_done", 32'(done), 32'h1);

        // Randomized operation mix
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse("rnd_rst");
            end else begin
                if ($urandom_range(0, 9) < 6) rm = 3'($urandom_range(1, 4));
                else                          rm = 3'($urandom_range(0, 7));
                cycle("rnd", 1'($urandom_range(0, 4) != 0), rm,
                      1'($urandom), 1'($urandom), 4'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
